// File: rtl/dual_line_read_scheduler_pkg.sv
// Shared defaults and state encoding for the dual camera line read scheduler.
package dual_line_read_scheduler_pkg;

    localparam int unsigned DefLineLen = 1280;
    localparam int unsigned DefLines   = 720;
    localparam int unsigned DefThresh  = 1000;
    localparam int unsigned DefUsedwW  = 14;
    localparam int unsigned DefSkewTmo = 4095;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLine,
        StRead,
        StLineEnd
    } sched_state_t;

endpackage

// File: rtl/dual_line_read_scheduler_if.sv
// FIFO fill levels in, shared read strobe and framed stream qualifiers out.
interface dual_line_read_scheduler_if #(
    parameter int unsigned USEDW_W = 14
);
    logic [USEDW_W-1:0] rdusedw_1;
    logic [USEDW_W-1:0] rdusedw_2;
    logic               rdreq;
    logic               valid;
    logic               sof;
    logic               eol;
    logic               eof;

    modport master (
        input  rdusedw_1, rdusedw_2,
        output rdreq, valid, sof, eol, eof
    );

    modport slave (
        output rdusedw_1, rdusedw_2,
        input  rdreq, valid, sof, eol, eof
    );
endinterface

// File: rtl/dual_line_read_scheduler_skew_watchdog.sv
// Counts consecutive cycles where only one FIFO is ready while waiting for a line.
module dual_line_read_scheduler_skew_watchdog #(
    parameter int unsigned SKEW_TMO = 4095
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic armed,
    input  logic skewed,
    input  logic clr_err,
    output logic err_skew
);
    localparam int unsigned CntW = $clog2(SKEW_TMO + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            hit;

    always_comb begin
        cnt_d = '0;
        hit   = 1'b0;
        if (armed && skewed) begin
            // Saturate at the timeout; the flag fires only on the cycle it is reached.
            cnt_d = (cnt_q == CntW'(SKEW_TMO)) ? cnt_q : cnt_q + 1'b1;
            hit   = (cnt_q == CntW'(SKEW_TMO - 1));
        end
        err_d = hit ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_skew = err_q;
endmodule

// File: rtl/dual_line_read_scheduler.sv
// Dual-FIFO line read scheduler: releases one line from both camera FIFOs in lockstep
// and frames the resulting stream with sof/eol/eof.
module dual_line_read_scheduler
    import dual_line_read_scheduler_pkg::*;
#(
    parameter int unsigned LINE_LEN = DefLineLen,
    parameter int unsigned LINES    = DefLines,
    parameter int unsigned THRESH   = DefThresh,
    parameter int unsigned USEDW_W  = DefUsedwW,
    parameter int unsigned SKEW_TMO = DefSkewTmo
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              frame_start,
    input  logic                              clr_err,
    dual_line_read_scheduler_if.master        bus,
    output logic [9:0]                        line_cnt,
    output logic [7:0]                        frame_cnt,
    output logic                              busy,
    output logic                              err_skew,
    output logic                              err_overrun
);
    localparam int unsigned WordW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [USEDW_W-1:0] Thresh = USEDW_W'(THRESH);

    sched_state_t     state_q, state_d;
    logic [WordW-1:0] word_q, word_d;
    logic [9:0]       line_q, line_d;
    logic [7:0]       frame_q, frame_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             valid_q, sof_q, eol_q, eof_q;
    logic             rdy_1, rdy_2, rd, last_word, last_line, overrun_hit;

    assign rdy_1       = (bus.rdusedw_1 >= Thresh);
    assign rdy_2       = (bus.rdusedw_2 >= Thresh);
    assign rd          = (state_q == StRead);
    assign last_word   = (word_q == WordW'(LINE_LEN - 1));
    assign last_line   = (line_q == 10'(LINES - 1));
    assign overrun_hit = frame_start && (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        line_d  = line_q;
        frame_d = frame_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (frame_start && enable) begin
                    state_d = StWaitLine;
                    line_d  = '0;
                end
            end
            StWaitLine: begin
                if (frame_start) begin
                    line_d = '0;
                end else if (rdy_1 && rdy_2) begin
                    state_d = StRead;
                    word_d  = '0;
                end
            end
            StRead: begin
                // A line in flight is never cut short; a new frame waits for its end.
                word_d = word_q + 1'b1;
                if (frame_start) pend_d = 1'b1;
                if (last_word) state_d = StLineEnd;
            end
            StLineEnd: begin
                pend_d = 1'b0;
                if (frame_start || pend_q) begin
                    state_d = StWaitLine;
                    line_d  = '0;
                end else if (last_line) begin
                    state_d = StIdle;
                    frame_d = frame_q + 8'd1;
                    line_d  = '0;
                end else if (!enable) begin
                    state_d = StIdle;
                    line_d  = '0;
                end else begin
                    state_d = StWaitLine;
                    line_d  = line_q + 10'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        ovr_d = overrun_hit ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            line_q  <= '0;
            frame_q <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            valid_q <= rd;
            sof_q   <= rd && (line_q == 10'd0) && (word_q == '0);
            eol_q   <= rd && last_word;
            eof_q   <= rd && last_word && last_line;
        end
    end

    dual_line_read_scheduler_skew_watchdog #(
        .SKEW_TMO (SKEW_TMO)
    ) u_skew_watchdog (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .armed    (state_q == StWaitLine),
        .skewed   (rdy_1 ^ rdy_2),
        .clr_err  (clr_err),
        .err_skew (err_skew)
    );

    assign bus.rdreq   = rd;
    assign bus.valid   = valid_q;
    assign bus.sof     = sof_q;
    assign bus.eol     = eol_q;
    assign bus.eof     = eof_q;
    assign line_cnt    = line_q;
    assign frame_cnt   = frame_q;
    assign busy        = (state_q != StIdle);
    assign err_overrun = ovr_q;
endmodule

// File: tb/tb_dual_line_read_scheduler.sv
// Bench for dual_line_read_scheduler: directed scenarios plus random stimulus, all
// checked every cycle against a position-based behavioural model.
module tb_dual_line_read_scheduler;
    localparam int unsigned LL  = 6;
    localparam int unsigned NL  = 3;
    localparam int unsigned TH  = 10;
    localparam int unsigned UW  = 5;
    localparam int unsigned TMO = 12;
    localparam int          L   = int'(LL);

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] line_cnt;
    logic [7:0] frame_cnt;
    logic       busy, err_skew, err_overrun;
    bit         chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int eof_seen = 0, sof_seen = 0, eol_seen = 0;

    dual_line_read_scheduler_if #(.USEDW_W(UW)) bus ();

    dual_line_read_scheduler #(
        .LINE_LEN (LL),
        .LINES    (NL),
        .THRESH   (TH),
        .USEDW_W  (UW),
        .SKEW_TMO (TMO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .clr_err     (clr_err),
        .bus         (bus),
        .line_cnt    (line_cnt),
        .frame_cnt   (frame_cnt),
        .busy        (busy),
        .err_skew    (err_skew),
        .err_overrun (err_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Model: m_pos = -2 idle, -1 waiting for fill, 0..L-1 word being read, L line gap.
    int m_pos, m_line, m_frames, m_skew;
    bit m_pend, m_valid, m_sof, m_eol, m_eof, m_eskew, m_eovr;

    task automatic model_init();
        m_pos = -2; m_line = 0; m_frames = 0; m_skew = 0; m_pend = 0;
        m_valid = 0; m_sof = 0; m_eol = 0; m_eof = 0; m_eskew = 0; m_eovr = 0;
    endtask

    task automatic model_step();
        bit rd, lastw, r1, r2, hit;
        if (reset) begin
            model_init();
            return;
        end
        rd    = (m_pos >= 0) && (m_pos < L);
        lastw = rd && (m_pos == L - 1);
        m_valid = rd;
        m_sof   = rd && (m_pos == 0) && (m_line == 0);
        m_eol   = lastw;
        m_eof   = lastw && (m_line == int'(NL) - 1);
        r1 = (int'(bus.rdusedw_1) >= int'(TH));
        r2 = (int'(bus.rdusedw_2) >= int'(TH));
        hit = 0;
        if (m_pos == -1 && r1 != r2) begin
            if (m_skew < int'(TMO)) begin
                m_skew++;
                hit = (m_skew == int'(TMO));
            end
        end else begin
            m_skew = 0;
        end
        if (hit) m_eskew = 1; else if (clr_err) m_eskew = 0;
        if (frame_start && m_pos != -2) m_eovr = 1; else if (clr_err) m_eovr = 0;
        if (m_pos == -2) begin
            if (frame_start && enable) begin m_pos = -1; m_line = 0; end
        end else if (m_pos == -1) begin
            if (frame_start) m_line = 0;
            else if (r1 && r2) m_pos = 0;
        end else if (m_pos < L) begin
            if (frame_start) m_pend = 1;
            m_pos++;
        end else begin
            if (frame_start || m_pend) begin
                m_pos = -1; m_line = 0;
            end else if (m_line == int'(NL) - 1) begin
                m_pos = -2; m_line = 0; m_frames++;
            end else if (!enable) begin
                m_pos = -2; m_line = 0;
            end else begin
                m_pos = -1; m_line++;
            end
            m_pend = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            model_step();
            #1;
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("cycle",
                  {6'd0, bus.rdreq, bus.valid, bus.sof, bus.eol, bus.eof, busy,
                   err_skew, err_overrun, line_cnt, frame_cnt},
                  {6'd0, (m_pos >= 0 && m_pos < L), m_valid, m_sof, m_eol, m_eof,
                   (m_pos != -2), m_eskew, m_eovr, 10'(m_line), 8'(m_frames)});
            if (bus.eof) eof_seen <= eof_seen + 1;
            if (bus.sof) sof_seen <= sof_seen + 1;
            if (bus.eol) eol_seen <= eol_seen + 1;
        end
    end

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && busy; i++) tick(1);
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int e0, s0, l0;
        model_init();
        bus.rdusedw_1 = '0;
        bus.rdusedw_2 = '0;
        tick(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdreq", 32'(bus.rdreq), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);

        // Reset mid-read
        enable = 1'b1;
        bus.rdusedw_1 = 5'd31;
        bus.rdusedw_2 = 5'd31;
        pulse_fs();
        for (int i = 0; i < 200 && !(bus.rdreq && line_cnt == 10'd1); i++) tick(1);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_mid_rdreq", 32'(bus.rdreq), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_line", 32'(line_cnt), 32'd0);
        check("rst_mid_flags", {29'd0, bus.valid, err_skew, err_overrun}, 32'd0);

        // Full frame at exactly the threshold
        bus.rdusedw_1 = 5'(TH);
        bus.rdusedw_2 = 5'(TH);
        e0 = eof_seen; s0 = sof_seen; l0 = eol_seen;
        pulse_fs();
        wait_idle("frame1_done");
        tick(1);
        check("frame1_eof", 32'(eof_seen - e0), 32'd1);
        check("frame1_sof", 32'(sof_seen - s0), 32'd1);
        check("frame1_eol", 32'(eol_seen - l0), 32'(NL));
        check("frame1_cnt", 32'(frame_cnt), 32'd1);

        // Skew: one FIFO one word short of the threshold
        bus.rdusedw_1 = 5'(TH - 1);
        bus.rdusedw_2 = 5'd31;
        pulse_fs();
        tick(TMO - 1);
        check("skew_before", 32'(err_skew), 32'd0);
        check("skew_no_rd", 32'(bus.rdreq), 32'd0);
        tick(1);
        check("skew_set", 32'(err_skew), 32'd1);
        bus.rdusedw_1 = 5'(TH);
        tick(1);
        check("skew_release", 32'(bus.rdreq), 32'd1);
        wait_idle("frame2_done");
        check("frame2_cnt", 32'(frame_cnt), 32'd2);

        // Overrun during a read: line finishes, then restart at line 0
        bus.rdusedw_1 = 5'd31;
        pulse_fs();
        for (int i = 0; i < 200 && !(bus.rdreq && line_cnt == 10'd1); i++) tick(1);
        tick(2);
        pulse_fs();
        check("ovr_set", 32'(err_overrun), 32'd1);
        check("ovr_line_holds", 32'(line_cnt), 32'd1);
        for (int i = 0; i < 200 && !(bus.rdreq && line_cnt == 10'd0); i++) tick(1);
        check("ovr_restart_line", 32'(line_cnt), 32'd0);
        wait_idle("frame3_done");
        check("frame3_cnt", 32'(frame_cnt), 32'd3);

        // Disable mid-line
        e0 = eof_seen; l0 = eol_seen;
        pulse_fs();
        for (int i = 0; i < 200 && !(bus.rdreq && line_cnt == 10'd1); i++) tick(1);
        enable = 1'b0;
        wait_idle("dis_done");
        tick(1);
        check("dis_line", 32'(line_cnt), 32'd0);
        check("dis_eol", 32'(eol_seen - l0), 32'd2);
        check("dis_no_eof", 32'(eof_seen - e0), 32'd0);
        check("dis_frame_cnt", 32'(frame_cnt), 32'd3);
        enable = 1'b1;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_flags", {30'd0, err_skew, err_overrun}, 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 799) == 0);
            enable      = ($urandom_range(0, 15) != 0);
            frame_start = ($urandom_range(0, 39) == 0);
            clr_err     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) bus.rdusedw_1 = 5'($urandom_range(TH - 3, 31));
            if ($urandom_range(0, 7) == 0) bus.rdusedw_2 = 5'($urandom_range(TH - 3, 31));
            tick(1);
        end
        frame_start = 1'b0;
        clr_err = 1'b0;
        enable = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // Frame counter wrap
        bus.rdusedw_1 = 5'd31;
        bus.rdusedw_2 = 5'd31;
        for (int f = 0; f < 256; f++) begin
            pulse_fs();
            for (int i = 0; i < 400 && busy; i++) tick(1);
            if (f == 254) check("frame_cnt_255", 32'(frame_cnt), 32'd255);
        end
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        // Overrun while waiting, then clear with no new error
        pulse_fs();
        pulse_fs();
        check("ovr_wait_set", 32'(err_overrun), 32'd1);
        wait_idle("final_done");
        check("final_frame_cnt", 32'(frame_cnt), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("final_clr", {30'd0, err_skew, err_overrun}, 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
